nonce_dispatcher: RTL
=====================

Name: nonce_dispatcher

Overview:
- Consumes the one-cycle `tick_in` enable produced by the miner's divide-by-4 clock divider, which pulses once every 4 `clk_in` cycles.
- Walks an inclusive nonce range [`range_lo`, `range_hi`] in steps of STRIDE.
- Offers one nonce per accepted tick to the downstream hash core over a valid/ready handshake.
- Reports progress (`issued_count`, `stall_count`) and completion (`done`) to the control logic.

Parameters:
- NONCE_W, 32, nonce width in bits.
- STRIDE, 1, increment between issued nonces; must be ≥1.
- CNT_W, 16, width of the saturating `stall_count` output.

Ports:
- clk_in, in, 1, system clock.
- reset, in, 1, asynchronous, active-high reset.
- tick_in, in, 1, issue enable from the clock divider; high for 1 cycle.
- start, in, 1, pulse; latches `range_lo`/`range_hi` and begins a sweep.
- abort, in, 1, pulse; ends the sweep immediately.
- range_lo, in, NONCE_W, first nonce, inclusive.
- range_hi, in, NONCE_W, last nonce, inclusive.
- nonce_out, out, NONCE_W, nonce offered to the hash core.
- nonce_valid, out, 1, `nonce_out` is valid.
- nonce_ready, in, 1, hash core accepts `nonce_out`.
- busy, out, 1, high in RUN and HOLD.
- done, out, 1, high in DONE until the next `start`.
- issued_count, out, NONCE_W, number of nonces accepted in the current sweep.
- stall_count, out, CNT_W, number of ticks dropped because a nonce was still pending; saturating.

Behaviour:
- Reset (async, active-high): state=IDLE. All outputs 0: `nonce_out`, `nonce_valid`, `busy`, `done`, `issued_count`, `stall_count`.
- Reset mid-sweep discards the sweep; no handshake completes.
- States: IDLE, RUN, HOLD, DONE.
- IDLE/DONE + `start`:
  - latch `range_lo` into `cur` and `range_hi` into `hi`;
  - clear `issued_count` and `stall_count`; `done`←0.
  - If `range_hi` < `range_lo` (unsigned): go to DONE, `issued_count`=0.
  - Otherwise go to RUN.
- `start` while in RUN or HOLD is ignored.
- RUN + `tick_in`: next cycle `nonce_out`=`cur`, `nonce_valid`=1, state=HOLD. Latency from tick to valid is 1 cycle.
- RUN without tick: wait; `nonce_valid`=0.
- HOLD:
  - `nonce_out` and `nonce_valid` are held stable until `nonce_valid`&`nonce_ready`.
  - Accept cycle: `issued_count`+1. Compute `rem` = `hi`−`cur` in NONCE_W+1 bits.
  - If `rem` < STRIDE: go to DONE next cycle; `nonce_valid`←0; `done`←1.
  - Otherwise: `cur`←`cur`+STRIDE.
    - If `tick_in` is high in the same cycle, present the new `cur` next cycle and stay in HOLD (back-to-back issue).
    - Otherwise go to RUN with `nonce_valid`←0.
  - `tick_in` while HOLD and not accepting: the tick is dropped; `stall_count`+1, saturating at all-ones.
- Range arithmetic never wraps: a sweep ending at 2^NONCE_W−1 terminates via the `rem` check, never by overflowing `cur`.
- `abort` (any state except IDLE): next cycle state=IDLE, `nonce_valid`=0, `busy`=0, `done`=0. Counters retain their values.
  - `abort` coinciding with an accept: the accept is counted, then go to IDLE.
  - `abort` and `start` in the same cycle: `abort` wins and `start` is ignored.
- `busy` = (state==RUN or state==HOLD), registered.
- `issued_count` holds its final value in DONE.
- `tick_in` is ignored in IDLE and DONE.

Test Plan:
- Divider `tick_in` every 4 cycles, `range_lo`=10, `range_hi`=13, `nonce_ready`=1:
  - nonces 10, 11, 12, 13 each valid 1 cycle after a tick;
  - `done`=1 after the 13 accept; `issued_count`=4; `stall_count`=0.
- `range_lo`=0xFFFFFFFE, `range_hi`=0xFFFFFFFF, STRIDE=1:
  - issues 0xFFFFFFFE then 0xFFFFFFFF, then DONE with no wrap to 0; `issued_count`=2.
- STRIDE=3, `range_lo`=0, `range_hi`=7:
  - issues 0, 3, 6, then DONE; `issued_count`=3.
- `nonce_ready` held low for 10 cycles across 2 ticks:
  - `nonce_out` stays stable at 5; `stall_count`=2; on ready, the next nonce is 6.
- `abort` asserted during HOLD with `nonce_out`=20:
  - next cycle `nonce_valid`=0, `busy`=0, `done`=0;
  - a subsequent `start` with `range_lo`=100 issues 100.
- `range_lo`=9, `range_hi`=4:
  - DONE 1 cycle after `start`; `nonce_valid` never asserts.
- Assert `reset` mid-HOLD:
  - all outputs go to 0 asynchronously, before the next `clk_in` edge.

Source files
------------

// File: rtl/nonce_dispatcher.sv
// Nonce dispatcher: walks an inclusive nonce range in STRIDE steps and offers
// one nonce per divider tick to the hash core over a valid/ready handshake.
module nonce_dispatcher #(
    parameter int NONCE_W = 32,
    parameter int STRIDE  = 1,
    parameter int CNT_W   = 16
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               tick_in,
    input  logic               start,
    input  logic               abort,
    input  logic [NONCE_W-1:0] range_lo,
    input  logic [NONCE_W-1:0] range_hi,
    output logic [NONCE_W-1:0] nonce_out,
    output logic               nonce_valid,
    input  logic               nonce_ready,
    output logic               busy,
    output logic               done,
    output logic [NONCE_W-1:0] issued_count,
    output logic [CNT_W-1:0]   stall_count
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [NONCE_W-1:0] STEP   = NONCE_W'(STRIDE);
    localparam logic [NONCE_W:0]   STEP_X = (NONCE_W+1)'(STRIDE);

    logic [1:0]         state_q, state_d;
    logic [NONCE_W-1:0] cur_q, cur_d;
    logic [NONCE_W-1:0] hi_q, hi_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic               valid_q, valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [NONCE_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0]   stall_q, stall_d;

    logic [NONCE_W:0]   rem;
    logic               accept;

    always_comb begin
        state_d  = state_q;
        cur_d    = cur_q;
        hi_d     = hi_q;
        nonce_d  = nonce_q;
        valid_d  = valid_q;
        issued_d = issued_q;
        stall_d  = stall_q;
        // One extra bit keeps the distance to the top of the range exact,
        // so a sweep ending at all-ones stops here instead of wrapping cur.
        rem      = {1'b0, hi_q} - {1'b0, cur_q};
        accept   = valid_q & nonce_ready;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start && !abort) begin
                    cur_d    = range_lo;
                    hi_d     = range_hi;
                    issued_d = '0;
                    stall_d  = '0;
                    valid_d  = 1'b0;
                    state_d  = (range_hi < range_lo) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                valid_d = 1'b0;
                if (tick_in) begin
                    nonce_d = cur_q;
                    valid_d = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (accept) begin
                    issued_d = issued_q + 1'b1;
                    if (rem < STEP_X) begin
                        valid_d = 1'b0;
                        state_d = S_DONE;
                    end else begin
                        cur_d = cur_q + STEP;
                        if (tick_in) begin
                            nonce_d = cur_q + STEP;
                            valid_d = 1'b1;
                        end else begin
                            valid_d = 1'b0;
                            state_d = S_RUN;
                        end
                    end
                end else if (tick_in && (stall_q != '1)) begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Abort overrides everything except the counter updates above.
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end

        busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cur_q    <= '0;
            hi_q     <= '0;
            nonce_q  <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            issued_q <= '0;
            stall_q  <= '0;
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            hi_q     <= hi_d;
            nonce_q  <= nonce_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            issued_q <= issued_d;
            stall_q  <= stall_d;
        end
    end

    assign nonce_out    = nonce_q;
    assign nonce_valid  = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign issued_count = issued_q;
    assign stall_count  = stall_q;

endmodule
